sejf_ctrl: RTL

//  Sequencing controller for the safe's code check. Collects three 2-digit BCD entries,

---
 rtl/sejf_pkg.sv | 21 ++
 rtl/sejf_timer.sv | 27 ++
 rtl/sejf_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sejf_pkg.sv
// rtl/sejf_pkg.sv - shared state encodings, widths and helper for the safe code-check controller
package sejf_pkg;

    localparam int SEL_W = 2;
    localparam int BCD_W = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CHECK   = 2'd1;
    localparam logic [1:0] ST_OPEN    = 2'd2;
    localparam logic [1:0] ST_LOCKOUT = 2'd3;

    // Largest of three cycle counts, used to size the shared timer
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/sejf_timer.sv
// rtl/sejf_timer.sv - loadable down-counter that holds at zero
module sejf_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load on request, otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/sejf_ctrl.sv
// rtl/sejf_ctrl.sv - safe code-check sequencer; optional idle timeout under SEJF_TIMEOUT_EN
module sejf_ctrl
    import sejf_pkg::*;
#(
    parameter int N_STEPS     = 3,
    parameter int MAX_FAIL    = 3,
    parameter int OPEN_CYC    = 2000,
    parameter int LOCKOUT_CYC = 1000,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enter,
    input  logic [BCD_W-1:0] bcd0_in,
    input  logic [BCD_W-1:0] bcd1_in,
    input  logic             lock_cmd,
    output logic [BCD_W-1:0] cmp_bcd0,
    output logic [BCD_W-1:0] cmp_bcd1,
    output logic [SEL_W-1:0] cmp_sel,
    input  logic             cmp_eq,
    output logic [SEL_W-1:0] step,
    output logic             unlocked,
    output logic             alarm,
    output logic             err
);

    localparam int TW = $clog2(max3(OPEN_CYC, LOCKOUT_CYC, TIMEOUT_CYC) + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);

    localparam logic [SEL_W-1:0] LAST_STEP = SEL_W'(N_STEPS - 1);
    localparam logic [FW-1:0]    FAIL_MAX  = FW'(MAX_FAIL);
    localparam logic [TW-1:0]    OPEN_LD   = TW'(OPEN_CYC - 1);
    localparam logic [TW-1:0]    LOCK_LD   = TW'(LOCKOUT_CYC - 1);

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [FW-1:0] fail_cnt;
    logic [FW-1:0] fail_inc;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_zero;
    logic          timeout_hit;

    assign cmp_sel  = step;
    assign fail_inc = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + FW'(1);

`ifdef SEJF_TIMEOUT_EN
    localparam logic [TW-1:0] TIMEOUT_LD = TW'(TIMEOUT_CYC - 1);
    // A partial entry left alone too long is forgotten; a fresh enter takes priority
    assign timeout_hit = (state == ST_IDLE) && !enter && (step != '0) && tmr_zero;
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state decision
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (enter) state_nx = ST_CHECK;
            ST_CHECK: begin
                if (cmp_eq) begin
                    state_nx = (step == LAST_STEP) ? ST_OPEN : ST_IDLE;
                end else begin
                    state_nx = (fail_inc == FAIL_MAX) ? ST_LOCKOUT : ST_IDLE;
                end
            end
            ST_OPEN:    if (lock_cmd || tmr_zero) state_nx = ST_IDLE;
            ST_LOCKOUT: if (tmr_zero) state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // The one shared timer is reloaded whenever the state changes
    always_comb begin
        tmr_load = (state_nx != state);
        tmr_val  = '0;
        case (state_nx)
            ST_OPEN:    tmr_val = OPEN_LD;
            ST_LOCKOUT: tmr_val = LOCK_LD;
`ifdef SEJF_TIMEOUT_EN
            ST_IDLE:    tmr_val = TIMEOUT_LD;
`endif
            default:    tmr_val = '0;
        endcase
    end

    sejf_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // State, step/fail bookkeeping and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            step     <= '0;
            fail_cnt <= '0;
            cmp_bcd0 <= '0;
            cmp_bcd1 <= '0;
            unlocked <= 1'b0;
            alarm    <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= state_nx;
            err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enter) begin
                        cmp_bcd0 <= bcd0_in;
                        cmp_bcd1 <= bcd1_in;
                    end else if (timeout_hit) begin
                        step <= '0;
                    end
                end
                ST_CHECK: begin
                    if (cmp_eq) begin
                        if (step == LAST_STEP) begin
                            unlocked <= 1'b1;
                            step     <= '0;
                            fail_cnt <= '0;
                        end else begin
                            step <= step + SEL_W'(1);
                        end
                    end else begin
                        err      <= 1'b1;
                        step     <= '0;
                        fail_cnt <= fail_inc;
                        alarm    <= (fail_inc == FAIL_MAX);
                    end
                end
                ST_OPEN: begin
                    if (lock_cmd || tmr_zero) unlocked <= 1'b0;
                end
                ST_LOCKOUT: begin
                    if (tmr_zero) begin
                        alarm    <= 1'b0;
                        fail_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
